// File: rtl/fir_mc_filter.sv
// fir_mc_filter: multi-channel time-multiplexed FIR with one shared MAC and a runtime-loadable coefficient RAM
module fir_mc_filter #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int NTAPS       = 16,
    parameter int NCH         = 2,
    parameter int OUT_SHIFT   = 7,
    parameter int COEFF_INIT  = 8,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int A_W   = $clog2(NTAPS),
    localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + A_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  xin,
    input  logic [CH_W-1:0]        xin_ch,
    input  logic                   we,
    output logic                   ready,
    input  logic                   coeff_we,
    input  logic [A_W-1:0]         coeff_addr,
    input  logic [COEFF_WIDTH-1:0] coeff_data,
    output logic                   coeff_err,
    output logic                   running,
    output logic [DATA_WIDTH-1:0]  xout,
    output logic [CH_W-1:0]        xout_ch,
    output logic                   xout_valid,
    output logic                   sat
);
    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    localparam int PW = DATA_WIDTH + COEFF_WIDTH;
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(2**(OUT_SHIFT-1));
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(DATA_WIDTH-1)-1);
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    state_t state_q, state_d;
    logic [A_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [A_W-1:0] wptr_q [NCH];
    logic [A_W-1:0] wptr_d [NCH];
    logic signed [DATA_WIDTH-1:0] hist_q [NCH][NTAPS];
    logic signed [DATA_WIDTH-1:0] hist_d [NCH][NTAPS];
    logic signed [COEFF_WIDTH-1:0] coef_q [NTAPS];
    logic signed [COEFF_WIDTH-1:0] coef_d [NTAPS];
    logic signed [DATA_WIDTH-1:0] h_q, h_d;
    logic signed [COEFF_WIDTH-1:0] c_q, c_d;
    logic v_q, v_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] xout_q, xout_d;
    logic [CH_W-1:0] xout_ch_q, xout_ch_d;
    logic xout_valid_q, xout_valid_d;
    logic sat_q, sat_d;
    logic coeff_err_q, coeff_err_d;

    logic accept;
    logic [A_W-1:0] wp, raddr;
    logic signed [PW-1:0] prod;
    logic signed [ACC_W:0] rnd, r;

    // history read address walks backwards from the newest sample, wrapping modulo NTAPS
    assign wp     = wptr_q[ch_q];
    assign raddr  = (wp >= cnt_q) ? wp - cnt_q : wp + (A_W'(NTAPS) - cnt_q);
    assign accept = (state_q == IDLE) && we && (int'(xin_ch) < NCH);
    assign prod   = h_q * c_q;
    assign rnd    = {acc_q[ACC_W-1], acc_q} + HALF;
    assign r      = rnd >>> OUT_SHIFT;

    // next-state, two-stage read/MAC pipe, history and coefficient updates
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        wptr_d       = wptr_q;
        hist_d       = hist_q;
        coef_d       = coef_q;
        h_d          = hist_q[ch_q][raddr];
        c_d          = coef_q[cnt_q];
        v_d          = (state_q == MAC);
        acc_d        = v_q ? acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod} : acc_q;
        xout_d       = xout_q;
        xout_ch_d    = xout_ch_q;
        xout_valid_d = 1'b0;
        sat_d        = 1'b0;
        coeff_err_d  = coeff_we && (state_q != IDLE);
        if (coeff_we && state_q == IDLE)
            coef_d[coeff_addr] = coeff_data;
        case (state_q)
            IDLE: if (accept) begin
                hist_d[xin_ch][wptr_q[xin_ch]] = xin;
                ch_d    = xin_ch;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                cnt_d   = (cnt_q == A_W'(NTAPS-1)) ? '0 : cnt_q + A_W'(1);
                state_d = (cnt_q == A_W'(NTAPS-1)) ? DRAIN : MAC;
            end
            DRAIN: begin
                cnt_d   = cnt_q + A_W'(1);
                state_d = (cnt_q == A_W'(1)) ? OUT : DRAIN;
            end
            default: begin
                state_d      = IDLE;
                xout_d       = (r > MAXV) ? MAXV[DATA_WIDTH-1:0] : (r < MINV) ? MINV[DATA_WIDTH-1:0] : r[DATA_WIDTH-1:0];
                xout_ch_d    = ch_q;
                xout_valid_d = 1'b1;
                sat_d        = (r > MAXV) || (r < MINV);
                wptr_d[ch_q] = (wp == A_W'(NTAPS-1)) ? '0 : wp + A_W'(1);
            end
        endcase
    end

    // state registers; reset drops any in-flight result and restores default coefficients
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ch_q         <= '0;
            h_q          <= '0;
            c_q          <= '0;
            v_q          <= 1'b0;
            acc_q        <= '0;
            xout_q       <= '0;
            xout_ch_q    <= '0;
            xout_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            coeff_err_q  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                wptr_q[i] <= '0;
                for (int j = 0; j < NTAPS; j++)
                    hist_q[i][j] <= '0;
            end
            for (int j = 0; j < NTAPS; j++)
                coef_q[j] <= COEFF_WIDTH'(COEFF_INIT);
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            h_q          <= h_d;
            c_q          <= c_d;
            v_q          <= v_d;
            acc_q        <= acc_d;
            xout_q       <= xout_d;
            xout_ch_q    <= xout_ch_d;
            xout_valid_q <= xout_valid_d;
            sat_q        <= sat_d;
            coeff_err_q  <= coeff_err_d;
            wptr_q       <= wptr_d;
            hist_q       <= hist_d;
            coef_q       <= coef_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign running    = (state_q != IDLE) || xout_valid_q;
    assign xout       = xout_q;
    assign xout_ch    = xout_ch_q;
    assign xout_valid = xout_valid_q;
    assign sat        = sat_q;
    assign coeff_err  = coeff_err_q;
endmodule

// File: tb/tb_fir_mc_filter.sv
// tb_fir_mc_filter: random and directed stimulus against a behavioural FIR model
module tb_fir_mc_filter;
    localparam int LAT = 19;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [7:0] xin = '0;
    logic xin_ch = 1'b0;
    logic we = 1'b0;
    logic ready;
    logic coeff_we = 1'b0;
    logic [3:0] coeff_addr = '0;
    logic signed [7:0] coeff_data = '0;
    logic coeff_err, running, xout_valid, sat;
    logic signed [7:0] xout;
    logic xout_ch;

    logic [1:0] t3_ch = '0;
    logic t3_we = 1'b0;
    logic t3_cwe = 1'b0;
    logic t3_ready, t3_cerr, t3_running, t3_valid, t3_sat;
    logic signed [7:0] t3_xout;
    logic [1:0] t3_xout_ch;

    always #5 clk = ~clk;

    fir_mc_filter dut (
        .clk(clk), .reset(reset), .xin(xin), .xin_ch(xin_ch), .we(we), .ready(ready),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .coeff_err(coeff_err), .running(running), .xout(xout), .xout_ch(xout_ch),
        .xout_valid(xout_valid), .sat(sat)
    );

    fir_mc_filter #(.NCH(3)) dut3 (
        .clk(clk), .reset(reset), .xin(xin), .xin_ch(t3_ch), .we(t3_we), .ready(t3_ready),
        .coeff_we(t3_cwe), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .coeff_err(t3_cerr), .running(t3_running), .xout(t3_xout), .xout_ch(t3_xout_ch),
        .xout_valid(t3_valid), .sat(t3_sat)
    );

    typedef struct {
        int t;
        int x;
        int ch;
        bit s;
    } exp_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int hist [2][16];
    int coef [16];
    exp_t q [$];
    bit err_pend = 1'b0;
    int got0 [$];
    int nz1 = 0;
    int last_x = 0;
    bit last_s = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 16; k++)
                hist[c][k] = 0;
        for (int k = 0; k < 16; k++)
            coef[k] = 8;
    endtask

    // sample enters tap 0 of its channel; output is the rounded, clipped dot product
    task automatic model_accept(input int x, input int ch, output int y, output bit s);
        int acc, rr;
        for (int k = 15; k > 0; k--)
            hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = x;
        acc = 0;
        for (int k = 0; k < 16; k++)
            acc += coef[k] * hist[ch][k];
        rr = (acc + 64) >>> 7;
        s = (rr > 127) || (rr < -128);
        y = (rr > 127) ? 127 : (rr < -128) ? -128 : rr;
    endtask

    task automatic push(input int x, input int ch, input bit cw = 1'b0, input int ca = 0, input int cd = 0);
        int w = 0;
        int y;
        bit s;
        @(negedge clk);
        while (!ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            check(1'b0, "ready_timeout", 0, 1);
            return;
        end
        we = 1'b1;
        xin = 8'(x);
        xin_ch = ch[0];
        if (cw) begin
            coeff_we = 1'b1;
            coeff_addr = 4'(ca);
            coeff_data = 8'(cd);
            coef[ca] = cd;
        end
        model_accept(x, ch, y, s);
        q.push_back('{cyc + 1, y, ch, s});
        @(negedge clk);
        we = 1'b0;
        coeff_we = 1'b0;
    endtask

    task automatic set_coef(input int k, input int v);
        @(negedge clk);
        coeff_we = 1'b1;
        coeff_addr = 4'(k);
        coeff_data = 8'(v);
        coef[k] = v;
        @(negedge clk);
        coeff_we = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (q.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (q.size() > 0) begin
            check(1'b0, "drain_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // every cycle: handshake flags, coefficient error pulse, and each result against the model
    initial begin
        exp_t e;
        bit act;
        forever begin
            @(posedge clk);
            #1;
            act = (q.size() > 0) && (cyc >= q[0].t);
            check(ready == !(act && cyc < q[0].t + LAT), "ready", int'(ready), int'(!(act && cyc < q[0].t + LAT)));
            check(running == act, "running", int'(running), int'(act));
            check(coeff_err == err_pend, "coeff_err", int'(coeff_err), int'(err_pend));
            if (xout_valid) begin
                if (q.size() == 0) begin
                    check(1'b0, "spurious_valid", int'(xout), 0);
                end else begin
                    e = q.pop_front();
                    check(cyc - e.t == LAT, "latency", cyc - e.t, LAT);
                    check(int'(xout) == e.x, "xout", int'(xout), e.x);
                    check(int'(xout_ch) == e.ch, "xout_ch", int'(xout_ch), e.ch);
                    check(sat == e.s, "sat", int'(sat), int'(e.s));
                    last_x = int'(xout);
                    last_s = sat;
                    if (xout_ch == 1'b0) got0.push_back(int'(xout));
                    else if (xout != 0) nz1++;
                end
            end else if (act && cyc >= q[0].t + LAT) begin
                check(1'b0, "missing_valid", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int k, lat;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check(ready == 1'b1 && xout == 0 && sat == 1'b0, "reset_state", int'(xout), 0);

        // DC gain: sixteen 100s with reset coefficients settle to 100
        for (int i = 0; i < 16; i++) push(100, 0);
        wait_idle();
        check(last_x == 100 && !last_s, "dc_final", last_x, 100);

        // impulse response through ramp coefficients
        do_reset();
        for (int i = 0; i < 16; i++) set_coef(i, 2 * (i + 1));
        got0.delete();
        push(64, 0);
        for (int i = 0; i < 15; i++) push(0, 0);
        wait_idle();
        check(got0.size() == 16, "impulse_count", got0.size(), 16);
        for (int i = 0; i < 16 && i < got0.size(); i++) check(got0[i] == i + 1, "impulse_tap", got0[i], i + 1);

        // saturation in both directions
        do_reset();
        for (int i = 0; i < 16; i++) set_coef(i, 127);
        for (int i = 0; i < 16; i++) push(127, 0);
        wait_idle();
        check(last_x == 127 && last_s, "sat_pos", last_x, 127);
        for (int i = 0; i < 16; i++) push(-128, 0);
        wait_idle();
        check(last_x == -128 && last_s, "sat_neg", last_x, -128);

        // channel isolation: impulse on ch0 interleaved with silence on ch1
        do_reset();
        for (int i = 0; i < 16; i++) set_coef(i, 2 * (i + 1));
        got0.delete();
        nz1 = 0;
        for (int i = 0; i < 16; i++) begin
            push(i == 0 ? 64 : 0, 0);
            push(0, 1);
        end
        wait_idle();
        check(nz1 == 0, "ch1_silent", nz1, 0);
        for (int i = 0; i < 16 && i < got0.size(); i++) check(got0[i] == i + 1, "iso_tap", got0[i], i + 1);

        // random samples and coefficients, including same-cycle and mid-MAC coefficient writes
        do_reset();
        for (int i = 0; i < 16; i++) set_coef(i, int'($urandom_range(0, 255)) - 128);
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < 2; c++) begin
                if ((i + c) % 7 == 3)
                    push(int'($urandom_range(0, 255)) - 128, c, 1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)) - 128);
                else
                    push(int'($urandom_range(0, 255)) - 128, c);
                if (i % 9 == 4) begin
                    coeff_we = 1'b1;
                    coeff_addr = 4'($urandom_range(0, 15));
                    coeff_data = 8'($urandom_range(0, 255));
                    err_pend = 1'b1;
                    @(negedge clk);
                    coeff_we = 1'b0;
                    err_pend = 1'b0;
                end
            end
        end
        wait_idle();

        // reset in the middle of MAC discards the result
        do_reset();
        push(64, 0);
        k = cyc;
        while (cyc < k + 4) @(negedge clk);
        reset = 1'b1;
        q.delete();
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        check(ready == 1'b1 && running == 1'b0, "post_reset_idle", int'(running), 0);
        repeat (25) @(negedge clk);
        got0.delete();
        push(64, 0);
        push(0, 0);
        wait_idle();
        check(got0.size() == 2, "post_reset_count", got0.size(), 2);
        for (int i = 0; i < 2 && i < got0.size(); i++) check(got0[i] == 4, "post_reset_xout", got0[i], 4);

        // three-channel instance: out-of-range channel is ignored, channel 2 works
        @(negedge clk);
        xin = 8'sd50;
        t3_ch = 2'd3;
        t3_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check(t3_ready && !t3_running && !t3_valid, "bad_ch_ignored", int'(t3_running), 0);
        end
        xin = 8'sd64;
        t3_ch = 2'd2;
        @(negedge clk);
        t3_we = 1'b0;
        lat = 0;
        while (!t3_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check(lat == LAT, "t3_latency", lat, LAT);
        check(int'(t3_xout) == 4 && t3_xout_ch == 2'd2 && !t3_sat, "t3_xout", int'(t3_xout), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
